// File: rtl/speicher_pkg.sv
// Shared types for the memory-port arbiter: FSM encoding, requester ids and
// the latched access descriptor.
package speicher_pkg;

    localparam int NUM_REQ = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ZUGRIFF = 2'd1,
        FERTIG  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        REQ_BEFEHL = 2'd0,
        REQ_DATEN  = 2'd1,
        REQ_EXT    = 2'd2
    } req_id_e;

    typedef struct packed {
        req_id_e id;
        logic    write;
    } zugriff_t;

    // Round-robin successor: Befehl -> Daten -> Ext -> Befehl
    function automatic req_id_e naechster(input req_id_e id);
        case (id)
            REQ_BEFEHL: return REQ_DATEN;
            REQ_DATEN:  return REQ_EXT;
            default:    return REQ_BEFEHL;
        endcase
    endfunction

    function automatic req_id_e onehot_to_id(input logic [NUM_REQ-1:0] oh);
        if (oh[REQ_EXT])        return REQ_EXT;
        else if (oh[REQ_DATEN]) return REQ_DATEN;
        else                    return REQ_BEFEHL;
    endfunction

endpackage

// File: rtl/speicher_arbiter_if.sv
// Requester and memory-controller signals of the arbiter; master = arbiter side,
// slave = the surrounding control FSM / memory controller / external master.
interface speicher_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          BefehlReq;
    logic [AW-1:0] BefehlAdresse;
    logic [DW-1:0] BefehlDaten;
    logic          BefehlGeladen;

    logic          LoadReq;
    logic          StoreReq;
    logic [AW-1:0] DatenAdresse;
    logic [DW-1:0] DatenSchreib;
    logic [DW-1:0] DatenLesen;
    logic          DatenGeladen;
    logic          DatenGespeichert;

    logic          ExtReq;
    logic          ExtWrite;
    logic [AW-1:0] ExtAdresse;
    logic [DW-1:0] ExtSchreib;
    logic [DW-1:0] ExtLesen;
    logic          ExtFertig;

    logic          MemReq;
    logic          MemWrite;
    logic [AW-1:0] MemAdresse;
    logic [DW-1:0] MemSchreibDaten;
    logic [DW-1:0] MemLeseDaten;
    logic          MemBereit;

    modport master (
        input  BefehlReq, BefehlAdresse,
        output BefehlDaten, BefehlGeladen,
        input  LoadReq, StoreReq, DatenAdresse, DatenSchreib,
        output DatenLesen, DatenGeladen, DatenGespeichert,
        input  ExtReq, ExtWrite, ExtAdresse, ExtSchreib,
        output ExtLesen, ExtFertig,
        output MemReq, MemWrite, MemAdresse, MemSchreibDaten,
        input  MemLeseDaten, MemBereit
    );

    modport slave (
        output BefehlReq, BefehlAdresse,
        input  BefehlDaten, BefehlGeladen,
        output LoadReq, StoreReq, DatenAdresse, DatenSchreib,
        input  DatenLesen, DatenGeladen, DatenGespeichert,
        output ExtReq, ExtWrite, ExtAdresse, ExtSchreib,
        input  ExtLesen, ExtFertig,
        input  MemReq, MemWrite, MemAdresse, MemSchreibDaten,
        output MemLeseDaten, MemBereit
    );

endinterface

// File: rtl/speicher_arbiter_wahl.sv
// Combinational 3-way grant select, one-hot result. SPEICHER_ARB_RR_EN selects
// round-robin starting after the last winner; otherwise fixed Daten > Befehl > Ext.
module speicher_arbiter_wahl
    import speicher_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
`ifdef SPEICHER_ARB_RR_EN
    input  req_id_e            letzter_i,
`endif
    output logic [NUM_REQ-1:0] grant_o
);

`ifdef SPEICHER_ARB_RR_EN
    req_id_e idx;

    always_comb begin
        grant_o = '0;
        idx     = naechster(letzter_i);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_i[idx] && grant_o == '0) grant_o[idx] = 1'b1;
            idx = naechster(idx);
        end
    end
`else
    always_comb begin
        grant_o = '0;
        if (req_i[REQ_DATEN])       grant_o[REQ_DATEN]  = 1'b1;
        else if (req_i[REQ_BEFEHL]) grant_o[REQ_BEFEHL] = 1'b1;
        else if (req_i[REQ_EXT])    grant_o[REQ_EXT]    = 1'b1;
    end
`endif

endmodule

// File: rtl/speicher_arbiter.sv
// Shares the single memory port between fetch, load/store and an external master.
// Define SPEICHER_ARB_RR_EN for round-robin priority (default: fixed priority).
module speicher_arbiter
    import speicher_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                Clock,
    input  logic                Reset,
    speicher_arbiter_if.master  bus
);

    state_e          state_q, state_d;
    zugriff_t        zug_q, zug_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [DW-1:0]   wdat_q, wdat_d;
    logic [DW-1:0]   befehl_q, befehl_d;
    logic [DW-1:0]   daten_q, daten_d;
    logic [DW-1:0]   ext_q, ext_d;

    logic [NUM_REQ-1:0] req, grant;
    req_id_e            gid;

    assign req[REQ_BEFEHL] = bus.BefehlReq;
    assign req[REQ_DATEN]  = bus.LoadReq | bus.StoreReq;
    assign req[REQ_EXT]    = bus.ExtReq;

`ifdef SPEICHER_ARB_RR_EN
    req_id_e letzter_q;

    speicher_arbiter_wahl u_wahl (
        .req_i     (req),
        .letzter_i (letzter_q),
        .grant_o   (grant)
    );

    // Pointer follows the winner as the access is entered
    always_ff @(posedge Clock) begin
        if (Reset)                          letzter_q <= REQ_BEFEHL;
        else if (state_q == IDLE && |req)   letzter_q <= gid;
    end
`else
    speicher_arbiter_wahl u_wahl (
        .req_i   (req),
        .grant_o (grant)
    );
`endif

    assign gid = onehot_to_id(grant);

    always_comb begin
        state_d  = state_q;
        zug_d    = zug_q;
        adr_d    = adr_q;
        wdat_d   = wdat_q;
        befehl_d = befehl_q;
        daten_d  = daten_q;
        ext_d    = ext_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d  = ZUGRIFF;
                    zug_d.id = gid;
                    case (gid)
                        REQ_DATEN: begin
                            // Store wins over a simultaneous load
                            adr_d       = bus.DatenAdresse;
                            wdat_d      = bus.DatenSchreib;
                            zug_d.write = bus.StoreReq;
                        end
                        REQ_EXT: begin
                            adr_d       = bus.ExtAdresse;
                            wdat_d      = bus.ExtSchreib;
                            zug_d.write = bus.ExtWrite;
                        end
                        default: begin
                            adr_d       = bus.BefehlAdresse;
                            zug_d.write = 1'b0;
                        end
                    endcase
                end
            end
            ZUGRIFF: begin
                if (bus.MemBereit) begin
                    state_d = FERTIG;
                    if (!zug_q.write) begin
                        case (zug_q.id)
                            REQ_DATEN: daten_d  = bus.MemLeseDaten;
                            REQ_EXT:   ext_d    = bus.MemLeseDaten;
                            default:   befehl_d = bus.MemLeseDaten;
                        endcase
                    end
                end
            end
            FERTIG:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            zug_q    <= '{id: REQ_BEFEHL, write: 1'b0};
            adr_q    <= '0;
            wdat_q   <= '0;
            befehl_q <= '0;
            daten_q  <= '0;
            ext_q    <= '0;
        end else begin
            state_q  <= state_d;
            zug_q    <= zug_d;
            adr_q    <= adr_d;
            wdat_q   <= wdat_d;
            befehl_q <= befehl_d;
            daten_q  <= daten_d;
            ext_q    <= ext_d;
        end
    end

    logic fertig;
    assign fertig = (state_q == FERTIG);

    assign bus.MemReq           = (state_q == ZUGRIFF);
    assign bus.MemWrite         = (state_q == ZUGRIFF) && zug_q.write;
    assign bus.MemAdresse       = adr_q;
    assign bus.MemSchreibDaten  = wdat_q;

    assign bus.BefehlGeladen    = fertig && zug_q.id == REQ_BEFEHL;
    assign bus.DatenGeladen     = fertig && zug_q.id == REQ_DATEN && !zug_q.write;
    assign bus.DatenGespeichert = fertig && zug_q.id == REQ_DATEN &&  zug_q.write;
    assign bus.ExtFertig        = fertig && zug_q.id == REQ_EXT;

    assign bus.BefehlDaten      = befehl_q;
    assign bus.DatenLesen       = daten_q;
    assign bus.ExtLesen         = ext_q;

endmodule

// File: tb/tb_speicher_arbiter.sv
// Bench for speicher_arbiter: directed scenarios plus randomized requesters,
// checked every cycle against a transaction-level reference model.
module tb_speicher_arbiter;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    speicher_arbiter_if #(.AW(32), .DW(32)) bus();

    speicher_arbiter #(.AW(32), .DW(32)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] ist, input logic [63:0] soll);
        n_chk++;
        if (ist !== soll) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, ist, soll);
        end
    endtask

    // Reference model: one outstanding access, identified by its owner;
    // a new grant is allowed from cycle free_at onwards.
    int          cyc = 0;
    bit          act = 0;
    int          own = 0;
    bit          mwr = 0;
    logic [31:0] madr = '0, mwdat = '0;
    int          done_at = -10, done_id = 0;
    bit          done_wr = 0;
    int          free_at = 0;
    int          lw = 0;
    logic [31:0] e_bef = '0, e_dat = '0, e_ext = '0;

    function automatic int pick();
        bit r[3];
        r[0] = bus.BefehlReq;
        r[1] = bus.LoadReq | bus.StoreReq;
        r[2] = bus.ExtReq;
`ifdef SPEICHER_ARB_RR_EN
        for (int i = 1; i <= 3; i++) if (r[(lw + i) % 3]) return (lw + i) % 3;
        return -1;
`else
        if (r[1]) return 1;
        if (r[0]) return 0;
        if (r[2]) return 2;
        return -1;
`endif
    endfunction

    task automatic modell();
        int w;
        cyc++;
        if (Reset) begin
            act = 0; done_at = -10; lw = 0; free_at = cyc + 1;
            e_bef = '0; e_dat = '0; e_ext = '0;
            return;
        end
        if (act) begin
            if (bus.MemBereit) begin
                act = 0; done_at = cyc; done_id = own; done_wr = mwr; free_at = cyc + 2;
                if (!mwr) begin
                    if (own == 0)      e_bef = bus.MemLeseDaten;
                    else if (own == 1) e_dat = bus.MemLeseDaten;
                    else               e_ext = bus.MemLeseDaten;
                end
            end
        end else if (cyc >= free_at) begin
            w = pick();
            if (w >= 0) begin
                act = 1; own = w; lw = w;
                if (w == 0)      begin madr = bus.BefehlAdresse; mwr = 0; end
                else if (w == 1) begin madr = bus.DatenAdresse; mwr = bus.StoreReq; mwdat = bus.DatenSchreib; end
                else             begin madr = bus.ExtAdresse; mwr = bus.ExtWrite; mwdat = bus.ExtSchreib; end
            end
        end
    endtask

    task automatic pruefe();
        bit d;
        d = (done_at == cyc);
        chk("MemReq", bus.MemReq, act);
        if (act) begin
            chk("MemAdresse", bus.MemAdresse, madr);
            chk("MemWrite", bus.MemWrite, mwr);
            if (mwr) chk("MemSchreibDaten", bus.MemSchreibDaten, mwdat);
        end else begin
            chk("MemWrite_idle", bus.MemWrite, 0);
        end
        chk("BefehlGeladen", bus.BefehlGeladen, d && done_id == 0);
        chk("DatenGeladen", bus.DatenGeladen, d && done_id == 1 && !done_wr);
        chk("DatenGespeichert", bus.DatenGespeichert, d && done_id == 1 && done_wr);
        chk("ExtFertig", bus.ExtFertig, d && done_id == 2);
        chk("BefehlDaten", bus.BefehlDaten, e_bef);
        chk("DatenLesen", bus.DatenLesen, e_dat);
        chk("ExtLesen", bus.ExtLesen, e_ext);
    endtask

    task automatic step();
        @(posedge Clock);
        modell();
        @(negedge Clock);
        pruefe();
    endtask

    task automatic alle_ruhig();
        bus.BefehlReq = 0; bus.LoadReq = 0; bus.StoreReq = 0; bus.ExtReq = 0;
    endtask

    // Runs n cycles, requesters drop their level on their done pulse and,
    // with rearm, raise it again one cycle later. Records the done order.
    int reihe[$];
    task automatic lauf(input int n, input bit rearm);
        bit rb = 0, rd = 0, re = 0;
        bit ld = 0, st = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (rb) begin bus.BefehlReq = 1; rb = 0; end
            if (rd) begin bus.LoadReq = ld; bus.StoreReq = st; rd = 0; end
            if (re) begin bus.ExtReq = 1; re = 0; end
            if (bus.BefehlGeladen) begin reihe.push_back(0); bus.BefehlReq = 0; rb = rearm; end
            if (bus.DatenGeladen || bus.DatenGespeichert) begin
                reihe.push_back(1); ld = bus.LoadReq; st = bus.StoreReq;
                bus.LoadReq = 0; bus.StoreReq = 0; rd = rearm;
            end
            if (bus.ExtFertig) begin reihe.push_back(2); bus.ExtReq = 0; re = rearm; end
        end
    endtask

    initial begin
        int cnt_req, cnt_st, cnt_ld;
        logic [31:0] alt;
        alle_ruhig();
        bus.BefehlAdresse = '0; bus.DatenAdresse = '0; bus.DatenSchreib = '0;
        bus.ExtWrite = 0; bus.ExtAdresse = '0; bus.ExtSchreib = '0;
        bus.MemLeseDaten = '0; bus.MemBereit = 0;

        // Reset state
        Reset = 1;
        repeat (3) step();
        chk("rst_MemAdresse", bus.MemAdresse, 0);
        chk("rst_MemSchreibDaten", bus.MemSchreibDaten, 0);
        chk("rst_MemReq", bus.MemReq, 0);
        Reset = 0;
        step();

        // Minimum latency fetch
        bus.BefehlReq = 1; bus.BefehlAdresse = 32'h100;
        bus.MemBereit = 1; bus.MemLeseDaten = 32'hCAFE0001;
        step();
        chk("t1_MemReq", bus.MemReq, 1);
        chk("t1_adr", bus.MemAdresse, 32'h100);
        step();
        chk("t1_geladen", bus.BefehlGeladen, 1);
        chk("t1_daten", bus.BefehlDaten, 32'hCAFE0001);
        bus.BefehlReq = 0; bus.MemBereit = 0;
        step();

        // Store with a 3-cycle memory
        bus.StoreReq = 1; bus.DatenAdresse = 32'h20; bus.DatenSchreib = 32'hDEADBEEF;
        cnt_req = 0; cnt_st = 0;
        for (int i = 0; i < 6; i++) begin
            bus.MemBereit = (i == 3);
            step();
            if (bus.MemReq) begin
                cnt_req++;
                chk("t2_write", bus.MemWrite, 1);
                chk("t2_wdat", bus.MemSchreibDaten, 32'hDEADBEEF);
            end
            if (bus.DatenGespeichert) begin cnt_st++; bus.StoreReq = 0; end
        end
        chk("t2_memreq_cycles", cnt_req, 3);
        chk("t2_pulses", cnt_st, 1);
        bus.MemBereit = 0;
        step();

`ifndef SPEICHER_ARB_RR_EN
        // Fixed priority: three simultaneous requests
        reihe.delete();
        bus.LoadReq = 1; bus.BefehlReq = 1; bus.ExtReq = 1; bus.ExtWrite = 0;
        bus.MemBereit = 1;
        lauf(12, 0);
        chk("t3_count", reihe.size(), 3);
        if (reihe.size() == 3) begin
            chk("t3_first", reihe[0], 1);
            chk("t3_second", reihe[1], 0);
            chk("t3_third", reihe[2], 2);
        end
`else
        // Round robin: two held requesters alternate
        reihe.delete();
        bus.BefehlReq = 1; bus.ExtReq = 1; bus.ExtWrite = 0;
        bus.MemBereit = 1;
        lauf(24, 1);
        chk("t4_count_ok", reihe.size() >= 6, 1);
        for (int i = 1; i < reihe.size(); i++) chk("t4_alternate", reihe[i] != reihe[i-1], 1);
`endif
        alle_ruhig(); bus.MemBereit = 0;
        repeat (2) step();

        // Load and store together: store only
        alt = bus.DatenLesen;
        reihe.delete();
        bus.LoadReq = 1; bus.StoreReq = 1; bus.DatenAdresse = 32'h44;
        bus.DatenSchreib = 32'h12345678; bus.MemBereit = 1; bus.MemLeseDaten = 32'h0BAD0BAD;
        cnt_ld = 0; cnt_st = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.DatenGeladen) cnt_ld++;
            if (bus.DatenGespeichert) begin cnt_st++; bus.LoadReq = 0; bus.StoreReq = 0; end
        end
        chk("t6_store_pulses", cnt_st, 1);
        chk("t6_load_pulses", cnt_ld, 0);
        chk("t6_lesen_kept", bus.DatenLesen, alt);
        bus.MemBereit = 0;
        step();

        // Reset in the middle of an access
        bus.BefehlReq = 1; bus.BefehlAdresse = 32'h300;
        step();
        chk("t5_in_access", bus.MemReq, 1);
        Reset = 1;
        step();
        chk("t5_memreq", bus.MemReq, 0);
        chk("t5_no_pulse", bus.BefehlGeladen, 0);
        Reset = 0; bus.BefehlReq = 0; bus.MemBereit = 1;
        step();
        chk("t5_no_late_pulse", bus.BefehlGeladen, 0);
        bus.MemBereit = 0;

        // Randomized requesters and memory latency
        for (int i = 0; i < 4000; i++) begin
            if (bus.BefehlGeladen) bus.BefehlReq = 0;
            else if (!bus.BefehlReq && $urandom_range(3) == 0) begin
                bus.BefehlReq = 1; bus.BefehlAdresse = $urandom;
            end else if (bus.BefehlReq && $urandom_range(15) == 0) bus.BefehlAdresse = $urandom;
            else if (bus.BefehlReq && $urandom_range(40) == 0) bus.BefehlReq = 0;

            if (bus.DatenGeladen || bus.DatenGespeichert) begin bus.LoadReq = 0; bus.StoreReq = 0; end
            else if (!(bus.LoadReq || bus.StoreReq) && $urandom_range(3) == 0) begin
                case ($urandom_range(2))
                    0: begin bus.LoadReq = 1; bus.StoreReq = 0; end
                    1: begin bus.LoadReq = 0; bus.StoreReq = 1; end
                    default: begin bus.LoadReq = 1; bus.StoreReq = 1; end
                endcase
                bus.DatenAdresse = $urandom; bus.DatenSchreib = $urandom;
            end else if ($urandom_range(15) == 0) begin
                bus.DatenAdresse = $urandom; bus.DatenSchreib = $urandom;
            end

            if (bus.ExtFertig) bus.ExtReq = 0;
            else if (!bus.ExtReq && $urandom_range(4) == 0) begin
                bus.ExtReq = 1; bus.ExtWrite = $urandom_range(1);
                bus.ExtAdresse = $urandom; bus.ExtSchreib = $urandom;
            end else if (bus.ExtReq && $urandom_range(15) == 0) begin
                bus.ExtWrite = $urandom_range(1); bus.ExtAdresse = $urandom;
            end

            bus.MemBereit = ($urandom_range(2) == 0);
            bus.MemLeseDaten = $urandom;
            Reset = ($urandom_range(500) == 0);
            step();
        end
        Reset = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
